// File: rtl/adder_multicycle.sv
// Multi-cycle N-bit adder: one CHUNK_BITS ripple slice per clock under a start/busy/done handshake.
// Optional signed-overflow flag enabled by defining ADDER_OVERFLOW_EN; otherwise overflow is tied low.
module adder_multicycle #(
    parameter int NUM_BITS   = 16,
    parameter int CHUNK_BITS = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    input  logic                carry_in,
    output logic                busy,
    output logic                done,
    output logic [NUM_BITS-1:0] sum,
    output logic                carry_out,
    output logic                overflow
);
    localparam int NUM_CHUNKS = NUM_BITS / CHUNK_BITS;
    localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
    localparam int MSB        = NUM_BITS - 1;

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t                state_reg, state_next;
    logic [NUM_BITS-1:0]   a_reg, b_reg;
    logic                  carry_reg;
    logic [IDX_W-1:0]      idx_reg;
    logic [CHUNK_BITS-1:0] part_reg [NUM_CHUNKS];
    logic [NUM_BITS-1:0]   sum_reg;
    logic                  carry_out_reg;

    logic [CHUNK_BITS-1:0] a_chunk [NUM_CHUNKS];
    logic [CHUNK_BITS-1:0] b_chunk [NUM_CHUNKS];
    logic [CHUNK_BITS-1:0] chunk_a, chunk_b;
    logic [CHUNK_BITS:0]   chunk_total;
    logic [NUM_BITS-1:0]   full_sum;
    logic                  accept;
    logic                  last_chunk;

    // full_sum splices the chunk being computed this cycle over the stored partials,
    // so the final edge can publish the complete result without an extra cycle.
    generate
        for (genvar gi = 0; gi < NUM_CHUNKS; gi++) begin : g_chunk
            assign a_chunk[gi] = a_reg[gi*CHUNK_BITS +: CHUNK_BITS];
            assign b_chunk[gi] = b_reg[gi*CHUNK_BITS +: CHUNK_BITS];
            assign full_sum[gi*CHUNK_BITS +: CHUNK_BITS] =
                (idx_reg == IDX_W'(gi)) ? chunk_total[CHUNK_BITS-1:0] : part_reg[gi];
        end
    endgenerate

    always_comb begin
        chunk_a = '0;
        chunk_b = '0;
        for (int i = 0; i < NUM_CHUNKS; i++) begin
            if (idx_reg == IDX_W'(i)) begin
                chunk_a = a_chunk[i];
                chunk_b = b_chunk[i];
            end
        end
    end

    assign chunk_total = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK_BITS{1'b0}}, carry_reg};
    assign last_chunk  = (idx_reg == IDX_W'(NUM_CHUNKS - 1));
    assign accept      = start && ((state_reg == IDLE) || (state_reg == DONE));

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = ADD;
            ADD:     if (last_chunk) state_next = DONE;
            DONE:    state_next = accept ? ADD : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            a_reg         <= '0;
            b_reg         <= '0;
            carry_reg     <= 1'b0;
            idx_reg       <= '0;
            sum_reg       <= '0;
            carry_out_reg <= 1'b0;
            for (int i = 0; i < NUM_CHUNKS; i++) part_reg[i] <= '0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                a_reg     <= a;
                b_reg     <= b;
                carry_reg <= carry_in;
                idx_reg   <= '0;
            end else if (state_reg == ADD) begin
                carry_reg <= chunk_total[CHUNK_BITS];
                for (int i = 0; i < NUM_CHUNKS; i++) begin
                    if (idx_reg == IDX_W'(i)) part_reg[i] <= chunk_total[CHUNK_BITS-1:0];
                end
                if (last_chunk) begin
                    idx_reg       <= '0;
                    sum_reg       <= full_sum;
                    carry_out_reg <= chunk_total[CHUNK_BITS];
                end else begin
                    idx_reg <= idx_reg + 1'b1;
                end
            end
        end
    end

`ifdef ADDER_OVERFLOW_EN
    logic overflow_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_reg <= 1'b0;
        end else if ((state_reg == ADD) && last_chunk) begin
            overflow_reg <= (a_reg[MSB] == b_reg[MSB]) && (full_sum[MSB] != a_reg[MSB]);
        end
    end

    assign overflow = overflow_reg;
`else
    assign overflow = 1'b0;
`endif

    assign busy      = (state_reg == ADD);
    assign done      = (state_reg == DONE);
    assign sum       = sum_reg;
    assign carry_out = carry_out_reg;

endmodule
